// File: rtl/vgaminikbd_pkg.sv
// Shared constants and types for the PS/2 keyboard path into the vgaminikbd terminal core.
// Event layout is {ext, brk, code}; FSM encodings live here so the bench and the RTL agree.
package vgaminikbd_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam int         EVT_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Key-event valid/ready bundle; the receiver is the master, the terminal core the slave.
// Head event fields are valid whenever evt_valid is high and hold until accepted.
interface ps2_kbd_rx_if;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       evt_valid;
  logic       evt_ready;

  modport master (output evt_code, evt_break, evt_ext, evt_valid, input evt_ready);
  modport slave  (input evt_code, evt_break, evt_ext, evt_valid, output evt_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO with combinational head read; push to full only succeeds with a same-cycle pop.
// Pointers carry an extra wrap bit so full/empty come from the MSB compare.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop, do_push;

  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign head_dat_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_dat_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// Receive-only PS/2 keyboard deframer: sync + glitch filter, 11-bit frame FSM, E0/F0 prefix folding.
// Falling edge acts 2+FILTER cycles after the raw edge; events queue in a FIFO, dropped with overflow when full.
module ps2_kbd_rx
  import vgaminikbd_pkg::*;
#(
  parameter int FILTER     = 4,
  parameter int TIMEOUT    = 2500,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         kbd_clk,
  input  logic         kbd_data,
  ps2_kbd_rx_if.master evt,
  output logic         frame_err,
  output logic         overflow
);
  localparam int FCW = $clog2(FILTER + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic           kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           kclk_f_q, kclk_fd_q;
  logic           kclk_fall;

  ps2_state_e     state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           par_ok_q;
  logic [TCW-1:0] to_cnt_q;
  logic           ext_pend_q, brk_pend_q;
  logic           frame_err_q, push_q;
  ps2_evt_t       push_evt_q;

  ps2_evt_t       head;
  logic           fifo_full, fifo_empty, pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      kclk_s1_q  <= 1'b1;
      kclk_s2_q  <= 1'b1;
      kdat_s1_q  <= 1'b1;
      kdat_s2_q  <= 1'b1;
      filt_cnt_q <= '0;
      kclk_f_q   <= 1'b1;
      kclk_fd_q  <= 1'b1;
    end else begin
      kclk_s1_q <= kbd_clk;
      kclk_s2_q <= kclk_s1_q;
      kdat_s1_q <= kbd_data;
      kdat_s2_q <= kdat_s1_q;
      kclk_fd_q <= kclk_f_q;
      // Any sample agreeing with the filtered level restarts the run count.
      if (kclk_s2_q == kclk_f_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FCW'(FILTER - 1)) begin
        kclk_f_q   <= kclk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FCW'(1);
      end
    end
  end

  assign kclk_fall = kclk_fd_q & ~kclk_f_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_evt_q  <= '0;
    end else begin
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      if (kclk_fall)                         to_cnt_q <= '0;
      else if (to_cnt_q != TCW'(TIMEOUT))    to_cnt_q <= to_cnt_q + TCW'(1);

      if (kclk_fall) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!kdat_s2_q) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q   <= {kdat_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok_q <= ^{shift_q, kdat_s2_q};
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (kdat_s2_q && par_ok_q) begin
              if (shift_q == PS2_PFX_EXT) begin
                ext_pend_q <= 1'b1;
              end else if (shift_q == PS2_PFX_BRK) begin
                brk_pend_q <= 1'b1;
              end else begin
                push_q     <= 1'b1;
                push_evt_q <= '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE && to_cnt_q == TCW'(TIMEOUT)) begin
        // Keyboard went quiet mid-frame: abandon it and any prefix it was building.
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
        ext_pend_q  <= 1'b0;
        brk_pend_q  <= 1'b0;
      end
    end
  end

  assign pop = evt.evt_valid & evt.evt_ready;

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push_q),
    .push_dat_i (push_evt_q),
    .pop_i      (pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_code  = head.code;
  assign evt.evt_break = head.brk;
  assign evt.evt_ext   = head.ext;
  assign frame_err     = frame_err_q;
  assign overflow      = push_q & fifo_full & ~pop;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames are modelled at byte level and the event stream,
// error pulses and overflow pulses are checked every cycle against that model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 2500;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic kbd_clk = 1'b1;
  logic kbd_data = 1'b1;
  logic frame_err, overflow;

  ps2_kbd_rx_if evt_if ();

  ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .kbd_clk   (kbd_clk),
    .kbd_data  (kbd_data),
    .evt       (evt_if),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-level model: expected event queue {ext,brk,code} plus outstanding pulse counts.
  logic [9:0] mq[$];
  bit m_ext = 0, m_brk = 0;
  int exp_err = 0, exp_ovf = 0;

  function automatic void model_byte(input logic [7:0] code, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (code == 8'hE0) begin
      m_ext = 1;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (mq.size() == DEPTH) exp_ovf++;
      else mq.push_back({m_ext, m_brk, code});
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit par_flip, input bit stop);
    logic par;
    par = ~(^code) ^ par_flip;
    return {stop, par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      kbd_data = bits[i];
      repeat (half) @(negedge clk);
      kbd_clk = 1'b0;
      repeat (half) @(negedge clk);
      kbd_clk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] code, input bit par_flip, input bit stop, input int half);
    model_byte(code, !par_flip && stop);
    send_bits(mk_frame(code, par_flip, stop), 11, half);
    repeat (half) @(negedge clk);
    kbd_data = 1'b1;
    repeat (2 * half) @(negedge clk);
  endtask

  // Drives the stop bit by hand and reports in which cycle after the raw fall things appear.
  task automatic timed_stop(input bit stopv, input int half, output int k_vld, output int k_err,
                            output int n_err, output logic [7:0] code_at);
    kbd_data = stopv;
    repeat (half) @(negedge clk);
    kbd_clk = 1'b0;
    k_vld = 0; k_err = 0; n_err = 0; code_at = 8'h00;
    for (int k = 1; k <= half; k++) begin
      @(negedge clk);
      if (evt_if.evt_valid && k_vld == 0) begin
        k_vld   = k;
        code_at = evt_if.evt_code;
      end
      if (frame_err) begin
        n_err++;
        if (k_err == 0) k_err = k;
      end
    end
    kbd_clk = 1'b1;
    repeat (half) @(negedge clk);
    kbd_data = 1'b1;
    repeat (2 * half) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    kbd_clk = 1'b0;
    repeat (len) @(negedge clk);
    kbd_clk = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic end_check(input string tag);
    repeat (20) @(negedge clk);
    chk({tag, "_queue_empty"}, 32'(mq.size()), 32'd0);
    chk({tag, "_err_pend"}, 32'(exp_err), 32'd0);
    chk({tag, "_ovf_pend"}, 32'(exp_ovf), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
    chk({tag, "_code"}, 32'(evt_if.evt_code), 32'd0);
    chk({tag, "_break"}, 32'(evt_if.evt_break), 32'd0);
    chk({tag, "_ext"}, 32'(evt_if.evt_ext), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  // Per-cycle compare against the model, sampled just after the falling edge.
  initial begin : cmp
    forever begin
      @(negedge clk);
      #1;
      if (resetn) begin
        if (evt_if.evt_valid) begin
          chk("evt_expected", 32'(mq.size() > 0), 32'd1);
          if (mq.size() > 0) begin
            chk("evt_head", 32'({evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}), 32'(mq[0]));
            if (evt_if.evt_ready) void'(mq.pop_front());
          end
        end
        if (frame_err) begin
          chk("ferr_expected", 32'(exp_err > 0), 32'd1);
          if (exp_err > 0) exp_err--;
        end
        if (overflow) begin
          chk("ovf_expected", 32'(exp_ovf > 0), 32'd1);
          if (exp_ovf > 0) exp_ovf--;
        end
      end
    end
  end

  initial begin : watchdog
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    int kv, ke, ne;
    logic [7:0] cat;
    evt_if.evt_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outputs("rst0");
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // 0x1C at 20 us bit period; stop fall to evt_valid is 2 sync + FILTER + 2 cycles.
    model_byte(8'h1C, 1'b1);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 10, 250);
    timed_stop(1'b1, 250, kv, ke, ne, cat);
    chk("t1_valid_cycle", 32'(kv), 32'd8);
    chk("t1_code", 32'(cat), 32'h1C);
    chk("t1_no_ferr", 32'(ne), 32'd0);
    end_check("t1");

    // E0 F0 74 folds into one event; held with ready low to inspect the head.
    evt_if.evt_ready = 1'b0;
    frame(8'hE0, 1'b0, 1'b1, 40);
    frame(8'hF0, 1'b0, 1'b1, 40);
    frame(8'h74, 1'b0, 1'b1, 40);
    chk("t2_one_event", 32'(mq.size()), 32'd1);
    chk("t2_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("t2_head", 32'({evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}), 32'h374);
    evt_if.evt_ready = 1'b1;
    end_check("t2a");
    frame(8'h1C, 1'b0, 1'b1, 40);
    end_check("t2b");

    // Bad parity: single error pulse one cycle after the stop edge is acted on.
    model_byte(8'h1C, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 10, 40);
    timed_stop(1'b1, 40, kv, ke, ne, cat);
    chk("t3_err_cycle", 32'(ke), 32'd7);
    chk("t3_err_count", 32'(ne), 32'd1);
    chk("t3_no_event", 32'(kv), 32'd0);
    frame(8'hF0, 1'b0, 1'b0, 40);
    frame(8'h1C, 1'b0, 1'b1, 40);
    end_check("t3");

    // Pending E0, then 5 bits and silence: timeout error drops the prefix.
    frame(8'hE0, 1'b0, 1'b1, 40);
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5, 40);
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    repeat (TIMEOUT + 300) @(negedge clk);
    chk("t4_timeout_err_seen", 32'(exp_err), 32'd0);
    frame(8'h29, 1'b0, 1'b1, 40);
    end_check("t4");

    // Overflow: fifth event is dropped, first four drain in order.
    evt_if.evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b1, 40);
    chk("t5_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("t5_head_code", 32'(evt_if.evt_code), 32'h01);
    chk("t5_queued", 32'(mq.size()), 32'd4);
    evt_if.evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_drained_valid", 32'(evt_if.evt_valid), 32'd0);
    end_check("t5");

    // Glitches below FILTER are ignored; exactly FILTER cycles is a real edge (bad start).
    glitch(1);
    glitch(FILTER - 1);
    end_check("t6a");
    exp_err++;
    glitch(FILTER);
    end_check("t6b");

    // Reset mid-frame with an E0 pending: no error, outputs at reset values, prefix gone.
    frame(8'hE0, 1'b0, 1'b1, 40);
    send_bits(mk_frame(8'h55, 1'b0, 1'b1), 5, 40);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst1");
    m_ext = 0;
    m_brk = 0;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    frame(8'h1C, 1'b0, 1'b1, 40);
    end_check("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
